// File: rtl/final_sel.sv
// Result selection with sequence stamping, build-hash gate and final handshake.
// Optional build-hash gate: define FINAL_HASH_CHECK_EN.
module final_sel #(
  parameter int unsigned W     = 4,
  parameter int unsigned SEQ_W = 64,
  parameter logic [31:0] HASH  = 32'd1519004575
) (
  input  logic             LVDS_CMD_CLK,
  input  logic             RESET_EXT,
  input  logic             COMBO_VALID,
  input  logic [W-1:0]     COMBO_DATA,
  input  logic             SEQ_VALID,
  input  logic [W-1:0]     SEQ_DATA,
  input  logic             HASH_VALID,
  input  logic [31:0]      HASH_IN,
  input  logic             FINAL_REQ,
  output logic [W-1:0]     OUT_DATA,
  output logic [SEQ_W-1:0] COMBO_SEQNUM,
  output logic [SEQ_W-1:0] SEQ_SEQNUM,
  output logic             ACTIVE,
  output logic             HASH_ERR,
  output logic             FINAL_DONE,
  output logic             OVF
);

  typedef enum logic [2:0] {
    S_CHECK,
    S_RUN,
    S_FINAL,
    S_DONE,
    S_ERROR
  } state_e;

`ifdef FINAL_HASH_CHECK_EN
  localparam state_e RST_STATE = S_CHECK;
`else
  localparam state_e RST_STATE = S_RUN;
`endif

  // One extra bit so "all stamps used" is representable.
  localparam logic [SEQ_W:0] MAX = {1'b0, {SEQ_W{1'b1}}};

  state_e           state_q;
  logic [SEQ_W:0]   next_q, next_d;
  logic [SEQ_W:0]   s_stamp;
  logic [W-1:0]     combo_q, seq_q;
  logic [SEQ_W-1:0] cseq_q, sseq_q;
  logic             ovf_q, herr_q;
  logic             run_ev, c_acc, s_acc, drop;

  always_comb begin
    run_ev  = (state_q == S_RUN) && !FINAL_REQ;
    c_acc   = run_ev && COMBO_VALID && (next_q <= MAX);
    s_stamp = next_q + {{SEQ_W{1'b0}}, c_acc};
    s_acc   = run_ev && SEQ_VALID && (s_stamp <= MAX);
    drop    = run_ev && ((COMBO_VALID && !c_acc)
                      || (SEQ_VALID && !s_acc));
    next_d  = s_stamp + {{SEQ_W{1'b0}}, s_acc};
  end

  always_ff @(posedge LVDS_CMD_CLK) begin
    if (RESET_EXT) begin
      state_q <= RST_STATE;
      next_q  <= {{SEQ_W{1'b0}}, 1'b1};
      combo_q <= '0;
      seq_q   <= '0;
      cseq_q  <= '0;
      sseq_q  <= '0;
      ovf_q   <= 1'b0;
      herr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_CHECK: begin
`ifdef FINAL_HASH_CHECK_EN
          if (HASH_VALID) begin
            if (HASH_IN == HASH) begin
              state_q <= S_RUN;
            end else begin
              state_q <= S_ERROR;
              herr_q  <= 1'b1;
            end
          end
`else
          state_q <= S_RUN;
`endif
        end
        S_RUN: begin
          if (FINAL_REQ) state_q <= S_FINAL;
          if (c_acc) begin
            combo_q <= COMBO_DATA;
            cseq_q  <= next_q[SEQ_W-1:0];
          end
          if (s_acc) begin
            seq_q  <= SEQ_DATA;
            sseq_q <= s_stamp[SEQ_W-1:0];
          end
          if (drop) ovf_q <= 1'b1;
          next_q <= next_d;
        end
        S_FINAL: state_q <= S_DONE;
        S_DONE:  state_q <= S_DONE;
        S_ERROR: state_q <= S_ERROR;
        default: state_q <= RST_STATE;
      endcase
    end
  end

`ifndef FINAL_HASH_CHECK_EN
  logic unused_hash;
  assign unused_hash = ^{HASH_VALID, HASH_IN, herr_q};
`endif

  // Newest stamp wins; ties (including post-reset) go to combo.
  assign OUT_DATA     = (state_q == S_ERROR) ? '0
                      : (sseq_q > cseq_q) ? seq_q : combo_q;
  assign COMBO_SEQNUM = cseq_q;
  assign SEQ_SEQNUM   = sseq_q;
  assign ACTIVE       = (state_q == S_RUN);
  assign FINAL_DONE   = (state_q == S_DONE);
  assign OVF          = ovf_q;
`ifdef FINAL_HASH_CHECK_EN
  assign HASH_ERR     = herr_q;
`else
  assign HASH_ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_final_sel.sv
// Directed bench for final_sel: default-width and 2-bit-stamp instances
// share stimulus; expected values are hand-computed.
module tb_final_sel;

  localparam logic [31:0] GOOD = 32'd1519004575;

  logic        clk = 1'b0;
  logic        rst;
  logic        cv, sv, hv, freq;
  logic [3:0]  cd, sd;
  logic [31:0] hin;

  logic [3:0]  a_out, b_out;
  logic [63:0] a_cs, a_ss;
  logic [1:0]  b_cs, b_ss;
  logic        a_act, a_herr, a_done, a_ovf;
  logic        b_act, b_herr, b_done, b_ovf;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  final_sel u_dut (
    .LVDS_CMD_CLK(clk), .RESET_EXT(rst),
    .COMBO_VALID(cv), .COMBO_DATA(cd),
    .SEQ_VALID(sv), .SEQ_DATA(sd),
    .HASH_VALID(hv), .HASH_IN(hin), .FINAL_REQ(freq),
    .OUT_DATA(a_out), .COMBO_SEQNUM(a_cs), .SEQ_SEQNUM(a_ss),
    .ACTIVE(a_act), .HASH_ERR(a_herr),
    .FINAL_DONE(a_done), .OVF(a_ovf)
  );

  final_sel #(.SEQ_W(2)) u_ovf (
    .LVDS_CMD_CLK(clk), .RESET_EXT(rst),
    .COMBO_VALID(cv), .COMBO_DATA(cd),
    .SEQ_VALID(sv), .SEQ_DATA(sd),
    .HASH_VALID(hv), .HASH_IN(hin), .FINAL_REQ(freq),
    .OUT_DATA(b_out), .COMBO_SEQNUM(b_cs), .SEQ_SEQNUM(b_ss),
    .ACTIVE(b_act), .HASH_ERR(b_herr),
    .FINAL_DONE(b_done), .OVF(b_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cv = 0; sv = 0; hv = 0; freq = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic start();
`ifdef FINAL_HASH_CHECK_EN
    hv = 1; hin = GOOD;
    tick();
`endif
  endtask

  task automatic ev(input logic c, input logic [3:0] c_d,
                    input logic s, input logic [3:0] s_d);
    cv = c; cd = c_d; sv = s; sd = s_d;
    tick();
  endtask

  initial begin
    rst = 1; cv = 0; sv = 0; hv = 0; freq = 0;
    cd = 0; sd = 0; hin = 0;
    tick(); tick();
    rst = 0;

    check("rst_out", a_out, 0);
    check("rst_cs", a_cs, 0);
    check("rst_ss", a_ss, 0);
    check("rst_flags", {a_herr, a_done, a_ovf}, 0);
`ifdef FINAL_HASH_CHECK_EN
    check("rst_act", a_act, 0);
`else
    check("rst_act", a_act, 1);
`endif

    // combo then seq
    start();
    check("run_act", a_act, 1);
    ev(1, 4'hA, 0, 0);
    check("c1_out", a_out, 4'hA);
    check("c1_cs", a_cs, 1);
    ev(0, 0, 1, 4'h5);
    check("s2_out", a_out, 4'h5);
    check("s2_ss", a_ss, 2);
    check("s2_cs", a_cs, 1);

    // simultaneous pair, then combo-only, then exhaustion on 2-bit stamps
    do_reset();
    start();
    ev(1, 4'h3, 1, 4'hC);
    check("pr_cs", a_cs, 1);
    check("pr_ss", a_ss, 2);
    check("pr_out", a_out, 4'hC);
    ev(1, 4'h6, 0, 0);
    check("c3_cs", a_cs, 3);
    check("c3_out", a_out, 4'h6);
    check("b_c3_out", b_out, 4'h6);
    check("b_c3_ovf", b_ovf, 0);
    ev(0, 0, 1, 4'h7);
    check("s4_ss", a_ss, 4);
    check("s4_out", a_out, 4'h7);
    check("a_no_ovf", a_ovf, 0);
    check("b_drop_ss", b_ss, 2);
    check("b_drop_out", b_out, 4'h6);
    check("b_ovf", b_ovf, 1);
    do_reset();
    check("b_rst_all", {b_out, b_cs, b_ss, b_ovf}, 0);
    check("a_rst_all", {a_out, a_ovf, a_done}, 0);
    check("a_rst_cs", a_cs, 0);

    // pair with only one stamp left: combo kept, seq dropped
    start();
    ev(1, 4'h1, 0, 0);
    ev(0, 0, 1, 4'h8);
    ev(1, 4'h2, 1, 4'h4);
    check("b_pr_cs", b_cs, 3);
    check("b_pr_ss", b_ss, 2);
    check("b_pr_out", b_out, 4'h2);
    check("b_pr_ovf", b_ovf, 1);
    check("a_pr_ss", a_ss, 4);
    check("a_pr_out", a_out, 4'h4);

    // final handshake; event coincident with FINAL_REQ is ignored
    do_reset();
    start();
    ev(1, 4'h9, 0, 0);
    check("f_out", a_out, 4'h9);
    freq = 1;
    ev(0, 0, 1, 4'hE);
    check("f1_act", a_act, 0);
    check("f1_done", a_done, 0);
    check("f1_out", a_out, 4'h9);
    tick();
    check("f2_done", a_done, 1);
    ev(0, 0, 1, 4'h1);
    check("f3_out", a_out, 4'h9);
    check("f3_ss", a_ss, 0);
    check("f3_done", a_done, 1);

    // reset wins mid-FINAL
    do_reset();
    start();
    freq = 1;
    tick();
    rst = 1;
    tick();
    rst = 0;
    tick();
    check("rf_done", a_done, 0);
`ifdef FINAL_HASH_CHECK_EN
    check("rf_act", a_act, 0);
`else
    check("rf_act", a_act, 1);
`endif

`ifdef FINAL_HASH_CHECK_EN
    // events before hash ignored; wrong hash is terminal
    do_reset();
    ev(1, 4'h5, 0, 0);
    check("pre_cs", a_cs, 0);
    hv = 1; hin = 32'd0;
    tick();
    check("bad_herr", a_herr, 1);
    check("bad_act", a_act, 0);
    ev(1, 4'hF, 0, 0);
    check("bad_out", a_out, 0);
    hv = 1; hin = GOOD;
    tick();
    check("bad_stay", a_act, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
